// File: rtl/param_cache.sv
// param_cache: N-way set-associative, write-back / write-allocate L1 cache
// with 256-bit lines, tree-PLRU replacement and saturating hit/miss counters.
// Hits complete in the request cycle; misses optionally write back the
// victim line and then fill from physical memory before the request hits.
module param_cache #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic [31:0]      mem_address,
    input  logic [31:0]      mem_byte_enable_l1,
    input  logic [255:0]     mem_wdata_l1,
    output logic             mem_resp,
    output logic [255:0]     mem_rdata_l1,
    output logic             stall_cache,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic [31:0]      pmem_address,
    output logic [255:0]     pmem_wdata,
    input  logic [255:0]     pmem_rdata,
    input  logic             pmem_resp,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = $clog2(NUM_WAYS);
    localparam int TAG_W  = 27 - IDX_W;
    localparam int PLRU_W = NUM_WAYS - 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t state_r, state_nxt_s;

    // Storage: tag/data are plain flops without reset, status bits are reset.
    logic [TAG_W-1:0]    tag_r   [NUM_SETS][NUM_WAYS];
    logic [255:0]        data_r  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0] valid_r [NUM_SETS];
    logic [NUM_WAYS-1:0] dirty_r [NUM_SETS];
    logic [PLRU_W-1:0]   plru_r  [NUM_SETS];

    // Miss context captured at the IDLE edge that detects the miss.
    logic [WAY_W-1:0]    victim_r;
    logic [IDX_W-1:0]    miss_idx_r;
    logic [31:0]         fill_addr_r;
    logic [31:0]         wb_addr_r;
    logic [255:0]        wb_data_r;
    logic                refill_r;
    logic [CNT_W-1:0]    hit_count_r;
    logic [CNT_W-1:0]    miss_count_r;

    logic                req_s;
    logic [IDX_W-1:0]    idx_s;
    logic [TAG_W-1:0]    tag_s;
    logic [NUM_WAYS-1:0] hit_vec_s;
    logic                hit_s;
    logic [WAY_W-1:0]    hit_way_s;
    logic [WAY_W-1:0]    inv_way_s;
    logic [WAY_W-1:0]    victim_s;
    logic                hit_evt_s;
    logic                miss_s;
    logic                fill_done_s;
    logic                unused_ok_s;

    // Mark accesses to a way: every tree node on its path points away from it.
    function automatic logic [PLRU_W-1:0] plru_touch(input logic [PLRU_W-1:0] tree,
                                                     input logic [WAY_W-1:0] way);
        logic [PLRU_W-1:0] t;
        int                node;
        logic              b;
        t    = tree;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            b           = way[WAY_W-1-l];
            t[node-1]   = ~b;
            node        = 2 * node + int'(b);
        end
        return t;
    endfunction

    // Follow the tree bits from the root to the least recently used way.
    function automatic logic [WAY_W-1:0] plru_victim(input logic [PLRU_W-1:0] tree);
        int node;
        node = 1;
        for (int l = 0; l < WAY_W; l++) begin
            node = 2 * node + int'(tree[node-1]);
        end
        return node[WAY_W-1:0];
    endfunction

    assign req_s       = mem_read | mem_write;
    assign idx_s       = mem_address[5 +: IDX_W];
    assign tag_s       = mem_address[31 -: TAG_W];
    assign unused_ok_s = ^mem_address[4:0];

    // Tag compare on every way of the indexed set and victim choice.
    always_comb begin
        hit_vec_s = '0;
        hit_way_s = '0;
        inv_way_s = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_s[w] = valid_r[idx_s][w] & (tag_r[idx_s][w] == tag_s);
            hit_way_s    = hit_way_s | (hit_vec_s[w] ? WAY_W'(w) : {WAY_W{1'b0}});
        end
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            inv_way_s = valid_r[idx_s][w] ? inv_way_s : WAY_W'(w);
        end
        hit_s    = |hit_vec_s;
        victim_s = (&valid_r[idx_s]) ? plru_victim(plru_r[idx_s]) : inv_way_s;
    end

    assign hit_evt_s   = (state_r == IDLE) & req_s & hit_s;
    assign miss_s      = (state_r == IDLE) & req_s & ~hit_s;
    assign fill_done_s = (state_r == FILL) & pmem_resp;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: a dirty valid victim goes through write-back first.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (miss_s) begin
                    state_nxt_s = (valid_r[idx_s][victim_s] & dirty_r[idx_s][victim_s])
                                  ? WRITEBACK : FILL;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WRITEBACK: begin
                if (pmem_resp) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = WRITEBACK;
                end
            end
            FILL: begin
                if (pmem_resp) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Outputs: pmem side decoded from the state register and latched miss context.
    always_comb begin
        mem_resp     = hit_evt_s;
        mem_rdata_l1 = hit_evt_s ? data_r[idx_s][hit_way_s] : 256'd0;
        stall_cache  = req_s & ~hit_evt_s;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = 256'd0;
        case (state_r)
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = wb_addr_r;
                pmem_wdata   = wb_data_r;
            end
            FILL: begin
                pmem_read    = 1'b1;
                pmem_address = fill_addr_r;
            end
            default: begin
                pmem_read    = 1'b0;
                pmem_write   = 1'b0;
            end
        endcase
        hit_count  = hit_count_r;
        miss_count = miss_count_r;
    end

    // Capture victim, addresses and victim line when a miss is detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            victim_r    <= '0;
            miss_idx_r  <= '0;
            fill_addr_r <= 32'd0;
            wb_addr_r   <= 32'd0;
            wb_data_r   <= 256'd0;
        end else if (miss_s) begin
            victim_r    <= victim_s;
            miss_idx_r  <= idx_s;
            fill_addr_r <= {tag_s, idx_s, 5'b00000};
            wb_addr_r   <= {tag_r[idx_s][victim_s], idx_s, 5'b00000};
            wb_data_r   <= data_r[idx_s][victim_s];
        end
    end

    // Tag/data arrays: line install on fill, byte merge on write hit.
    always_ff @(posedge clk) begin
        if (fill_done_s) begin
            tag_r[miss_idx_r][victim_r]  <= fill_addr_r[31 -: TAG_W];
            data_r[miss_idx_r][victim_r] <= pmem_rdata;
        end else if (hit_evt_s && mem_write) begin
            for (int b = 0; b < 32; b++) begin
                if (mem_byte_enable_l1[b]) begin
                    data_r[idx_s][hit_way_s][8*b +: 8] <= mem_wdata_l1[8*b +: 8];
                end
            end
        end
    end

    // Valid, dirty and PLRU state per set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
                plru_r[s]  <= '0;
            end
        end else if (fill_done_s) begin
            valid_r[miss_idx_r][victim_r] <= 1'b1;
            dirty_r[miss_idx_r][victim_r] <= 1'b0;
            plru_r[miss_idx_r]            <= plru_touch(plru_r[miss_idx_r], victim_r);
        end else if (hit_evt_s) begin
            plru_r[idx_s] <= plru_touch(plru_r[idx_s], hit_way_s);
            if (mem_write) begin
                dirty_r[idx_s][hit_way_s] <= 1'b1;
            end
        end
    end

    // Saturating counters; the hit that completes a refilled request is not a hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count_r  <= '0;
            miss_count_r <= '0;
            refill_r     <= 1'b0;
        end else begin
            if (fill_done_s) begin
                refill_r <= req_s;
            end else if (state_r == IDLE) begin
                refill_r <= 1'b0;
            end
            if (hit_evt_s && !refill_r && (hit_count_r != {CNT_W{1'b1}})) begin
                hit_count_r <= hit_count_r + CNT_W'(1);
            end
            if (miss_s && (miss_count_r != {CNT_W{1'b1}})) begin
                miss_count_r <= miss_count_r + CNT_W'(1);
            end
        end
    end

endmodule
